// File: rtl/otter_io_pkg.sv
// Shared definitions for the OTTER MMIO UART transmitter: register offsets,
// STATUS/CTRL bit positions and the transmit state encoding.
package otter_io_pkg;

    localparam logic [3:0] OFF_TXDATA = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_CTRL   = 4'h8;
    localparam logic [3:0] OFF_BAUD   = 4'hC;

    localparam int unsigned ST_EMPTY = 8;
    localparam int unsigned ST_FULL  = 9;
    localparam int unsigned ST_BUSY  = 10;
    localparam int unsigned ST_OVF   = 11;

    localparam int unsigned CT_TX_EN   = 0;
    localparam int unsigned CT_FLUSH   = 1;
    localparam int unsigned CT_CLR_OVF = 2;
    localparam int unsigned CT_IRQ_EN  = 3;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. A push into a full FIFO is only
// taken when a pop happens in the same cycle; flush empties it and discards
// any same-cycle push.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && !flush && (!full || do_pop);

    // Storage array; written only on accepted pushes
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/iobus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the OTTER MMIO bus. Bytes written to
// TXDATA are queued in a FIFO and shifted out LSB first on TX.
module iobus_uart_tx
    import otter_io_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h1100_0100,
    parameter int unsigned CLK_RATE   = 50,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] IOBUS_IN,
    output logic        TX,
    output logic        IRQ
);

    localparam int unsigned CW            = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned RESET_DIV_INT = CLK_RATE * 1_000_000 / BAUD;
    localparam logic [15:0] RESET_DIV     = RESET_DIV_INT[15:0];

    logic          sel;
    logic [3:0]    off;
    logic          wr_txdata;
    logic          wr_ctrl;
    logic          wr_baud;
    logic          flush;
    logic          clr_ovf;
    logic          push;
    logic          pop;
    logic          ovf_event;

    logic          tx_en;
    logic          irq_en;
    logic [15:0]   baud_div;
    logic [15:0]   eff_div;
    logic          overflow;

    logic [7:0]    fifo_data;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    tx_state_t     state;
    logic [7:0]    shift;
    logic [2:0]    bit_cnt;
    logic [15:0]   baud_cnt;
    logic [15:0]   div_lat;

    logic          unused_bits;
    assign unused_bits = ^IOBUS_OUT[31:16];

    assign sel       = (IOBUS_ADDR[31:4] == BASE_ADDR[31:4]);
    assign off       = IOBUS_ADDR[3:0];
    assign wr_txdata = IOBUS_WR && sel && (off == OFF_TXDATA);
    assign wr_ctrl   = IOBUS_WR && sel && (off == OFF_CTRL);
    assign wr_baud   = IOBUS_WR && sel && (off == OFF_BAUD);
    assign flush     = wr_ctrl && IOBUS_OUT[CT_FLUSH];
    assign clr_ovf   = wr_ctrl && IOBUS_OUT[CT_CLR_OVF];
    assign push      = wr_txdata;
    assign eff_div   = (baud_div < 16'd2) ? 16'd2 : baud_div;

    // A new frame may start from IDLE or in the last STOP cycle, giving
    // back-to-back frames without an idle bit between them.
    assign pop = tx_en && !fifo_empty &&
                 ((state == TX_IDLE) || ((state == TX_STOP) && (baud_cnt == '0)));

    assign ovf_event = push && !flush && fifo_full && !pop;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RESET_N),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (IOBUS_OUT[7:0]),
        .rdata (fifo_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Configuration registers and sticky overflow flag (set beats clear)
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            tx_en    <= 1'b1;
            irq_en   <= 1'b0;
            baud_div <= RESET_DIV;
            overflow <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                tx_en  <= IOBUS_OUT[CT_TX_EN];
                irq_en <= IOBUS_OUT[CT_IRQ_EN];
            end
            if (wr_baud) begin
                baud_div <= IOBUS_OUT[15:0];
            end
            if (ovf_event) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    // Transmit FSM; TX is registered from the current state, so the line
    // trails the state by one cycle uniformly across every bit.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= TX_IDLE;
            TX       <= 1'b1;
            shift    <= '0;
            bit_cnt  <= '0;
            baud_cnt <= '0;
            div_lat  <= RESET_DIV;
        end else begin
            unique case (state)
                TX_START: TX <= 1'b0;
                TX_DATA:  TX <= shift[0];
                default:  TX <= 1'b1;
            endcase

            if (pop) begin
                shift    <= fifo_data;
                div_lat  <= eff_div;
                baud_cnt <= eff_div - 16'd1;
                state    <= TX_START;
            end else begin
                unique case (state)
                    TX_IDLE: begin
                        state <= TX_IDLE;
                    end
                    TX_START: begin
                        if (baud_cnt == '0) begin
                            baud_cnt <= div_lat - 16'd1;
                            bit_cnt  <= '0;
                            state    <= TX_DATA;
                        end else begin
                            baud_cnt <= baud_cnt - 16'd1;
                        end
                    end
                    TX_DATA: begin
                        if (baud_cnt == '0) begin
                            baud_cnt <= div_lat - 16'd1;
                            shift    <= {1'b0, shift[7:1]};
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state <= TX_STOP;
                            end
                        end else begin
                            baud_cnt <= baud_cnt - 16'd1;
                        end
                    end
                    TX_STOP: begin
                        if (baud_cnt == '0) begin
                            state <= TX_IDLE;
                        end else begin
                            baud_cnt <= baud_cnt - 16'd1;
                        end
                    end
                endcase
            end
        end
    end

    // Registered interrupt: transmitter drained and idle
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            IRQ <= 1'b0;
        end else begin
            IRQ <= irq_en && fifo_empty && (state == TX_IDLE);
        end
    end

    // Read mux; zero outside the window so several responders can be ORed
    always_comb begin
        IOBUS_IN = '0;
        if (sel) begin
            unique case (off)
                OFF_STATUS: begin
                    IOBUS_IN[4:0]    = 5'(fifo_count);
                    IOBUS_IN[ST_EMPTY] = fifo_empty;
                    IOBUS_IN[ST_FULL]  = fifo_full;
                    IOBUS_IN[ST_BUSY]  = (state != TX_IDLE);
                    IOBUS_IN[ST_OVF]   = overflow;
                end
                OFF_CTRL: begin
                    IOBUS_IN[CT_TX_EN]  = tx_en;
                    IOBUS_IN[CT_IRQ_EN] = irq_en;
                end
                OFF_BAUD: begin
                    IOBUS_IN[15:0] = baud_div;
                end
                default: begin
                    IOBUS_IN = '0;
                end
            endcase
        end
    end

endmodule
